// File: rtl/kv_defines_pkg.sv
// Shared definitions for the key-vault key reader: FSM state encoding,
// read-control register bit positions and the wait-timeout limit.
package kv_defines_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } kv_rd_state_e;

  // read-control register layout: bit0 start, entry index above it
  localparam int CTRL_RD_EN_BIT  = 0;
  localparam int CTRL_ENTRY_LSB  = 1;

  localparam int KV_OFFSET_W = 3;

  // WAIT cycles without a vault response before the flow is aborted
  localparam logic [7:0] KV_RD_TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/aes_kv_key_reader.sv
// Fetches an AES key from the key vault one dword at a time and writes each
// returned dword straight into the AES key register.
// Optional feature: define KV_RD_TIMEOUT_EN to abort a flow to ERR when the
// vault stays silent for KV_RD_TIMEOUT_LIMIT cycles in WAIT.
//
// state | meaning
// IDLE  | ready for a start write on the read-control register
// REQ   | present request for the current dword offset
// WAIT  | request held until the vault answers
// DONE  | all dwords written, set rd_done
// ERR   | vault error (or timeout), set rd_err
module aes_kv_key_reader
  import kv_defines_pkg::*;
#(
  parameter int NUM_DWORDS = 8,
  parameter int ENTRY_W    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ctrl_we,
  input  logic [ENTRY_W:0]       ctrl_wdata,
  output logic                   kv_rd_req,
  output logic [ENTRY_W-1:0]     kv_rd_entry,
  output logic [KV_OFFSET_W-1:0] kv_rd_offset,
  input  logic                   kv_rd_valid,
  input  logic [31:0]            kv_rd_data,
  input  logic                   kv_rd_error,
  output logic                   key_write_en,
  output logic [KV_OFFSET_W-1:0] key_write_offset,
  output logic [31:0]            key_write_data,
  output logic                   rd_ready,
  output logic                   rd_done,
  output logic                   rd_err,
  output logic                   flow_ip
);

  localparam logic [KV_OFFSET_W-1:0] LAST_OFFSET = KV_OFFSET_W'(NUM_DWORDS - 1);

  kv_rd_state_e           state_q, state_d;
  logic [KV_OFFSET_W-1:0] offset_q;
  logic [ENTRY_W-1:0]     entry_q;
  logic                   rd_done_q, rd_err_q;
  logic                   start;

`ifdef KV_RD_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and flow outputs; the key write is combinational from the response
  always_comb begin
    state_d      = state_q;
    kv_rd_req    = 1'b0;
    key_write_en = 1'b0;
    rd_ready     = 1'b0;
    flow_ip      = 1'b1;
    start        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_ready = 1'b1;
        flow_ip  = 1'b0;
        if (ctrl_we && ctrl_wdata[CTRL_RD_EN_BIT]) begin
          start   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        kv_rd_req = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        kv_rd_req = 1'b1;
        if (kv_rd_valid) begin
          if (kv_rd_error) begin
            state_d = ST_ERR;
          end else begin
            key_write_en = 1'b1;
            state_d      = (offset_q == LAST_OFFSET) ? ST_DONE : ST_REQ;
          end
        end
`ifdef KV_RD_TIMEOUT_EN
        else if (wait_cnt_q == KV_RD_TIMEOUT_LIMIT - 8'd1) begin
          state_d = ST_ERR;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Entry latch, dword offset counter (halts at the last dword) and sticky status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offset_q  <= '0;
      entry_q   <= '0;
      rd_done_q <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      if (start) begin
        entry_q   <= ctrl_wdata[ENTRY_W:CTRL_ENTRY_LSB];
        offset_q  <= '0;
        rd_done_q <= 1'b0;
        rd_err_q  <= 1'b0;
      end
      if (key_write_en && (offset_q != LAST_OFFSET)) offset_q <= offset_q + 1'b1;
      if (state_q == ST_DONE) rd_done_q <= 1'b1;
      if (state_q == ST_ERR)  rd_err_q  <= 1'b1;
    end
  end

`ifdef KV_RD_TIMEOUT_EN
  // Counts silent WAIT cycles; restarted for every dword request
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               wait_cnt_q <= '0;
    else if (state_q == ST_REQ)              wait_cnt_q <= '0;
    else if (state_q == ST_WAIT && !kv_rd_valid) wait_cnt_q <= wait_cnt_q + 8'd1;
  end
`endif

  assign kv_rd_entry      = entry_q;
  assign kv_rd_offset     = offset_q;
  assign key_write_offset = offset_q;
  assign key_write_data   = kv_rd_data;
  assign rd_done          = rd_done_q;
  assign rd_err           = rd_err_q;

endmodule

// File: tb/tb_aes_kv_key_reader.sv
// Self-checking bench for aes_kv_key_reader: a vault responder with
// programmable latency/error, and a flow-level model (expected write list,
// flow length and request-cycle count) checked every cycle.
module tb_aes_kv_key_reader;

  localparam int NUM     = 8;
  localparam int ENTRY_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              ctrl_we;
  logic [ENTRY_W:0]  ctrl_wdata;
  logic              kv_rd_req;
  logic [ENTRY_W-1:0] kv_rd_entry;
  logic [2:0]        kv_rd_offset;
  logic              kv_rd_valid;
  logic [31:0]       kv_rd_data;
  logic              kv_rd_error;
  logic              key_write_en;
  logic [2:0]        key_write_offset;
  logic [31:0]       key_write_data;
  logic              rd_ready, rd_done, rd_err, flow_ip;

  aes_kv_key_reader #(.NUM_DWORDS(NUM), .ENTRY_W(ENTRY_W)) dut (
    .clk(clk), .reset(reset),
    .ctrl_we(ctrl_we), .ctrl_wdata(ctrl_wdata),
    .kv_rd_req(kv_rd_req), .kv_rd_entry(kv_rd_entry), .kv_rd_offset(kv_rd_offset),
    .kv_rd_valid(kv_rd_valid), .kv_rd_data(kv_rd_data), .kv_rd_error(kv_rd_error),
    .key_write_en(key_write_en), .key_write_offset(key_write_offset),
    .key_write_data(key_write_data),
    .rd_ready(rd_ready), .rd_done(rd_done), .rd_err(rd_err), .flow_ip(flow_ip)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] off; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int writes_seen = 0;
  int req_cycles = 0;
  int exp_entry = 0;
  logic [2:0]  last_woff = '0;
  logic [31:0] last_wdata = '0;

  int vault_lat = 1;
  int vault_err_off = 99;
  bit vault_on = 1'b0;
  bit vault_spurious = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dword_of(input int i);
    return 32'h1111_1111 * 32'(i + 1);
  endfunction

  // Key-vault responder: answers a held request after vault_lat cycles
  initial begin
    int lat_cnt;
    lat_cnt = 0;
    kv_rd_valid = 1'b0; kv_rd_error = 1'b0; kv_rd_data = '0;
    forever begin
      @(negedge clk);
      kv_rd_valid = 1'b0;
      kv_rd_error = 1'b0;
      if (vault_spurious) begin
        kv_rd_valid = 1'b1;
        kv_rd_data  = 32'hDEAD_BEEF;
      end else if (vault_on && kv_rd_req) begin
        if (lat_cnt >= vault_lat) begin
          kv_rd_valid = 1'b1;
          kv_rd_data  = dword_of(int'(kv_rd_offset));
          kv_rd_error = (int'(kv_rd_offset) == vault_err_off);
          lat_cnt = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Per-cycle compare against the expected write list
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        chk("ready_is_not_flow_ip", 32'(rd_ready), 32'(!flow_ip));
        if (kv_rd_req) req_cycles++;
        if (key_write_en) begin
          writes_seen++;
          last_woff  = key_write_offset;
          last_wdata = key_write_data;
          if (exp_q.size() == 0) begin
            chk("unexpected_key_write", 32'(key_write_en), 32'd0);
          end else begin
            w = exp_q.pop_front();
            chk("key_write_offset", 32'(key_write_offset), 32'(w.off));
            chk("key_write_data", key_write_data, w.data);
            chk("entry_during_write", 32'(kv_rd_entry), 32'(exp_entry));
          end
        end
      end
    end
  end

  task automatic start_flow(input int entry);
    @(negedge clk);
    ctrl_we = 1'b1;
    ctrl_wdata = {ENTRY_W'(entry), 1'b1};
    @(posedge clk);
    #1;
    ctrl_we = 1'b0;
    chk("start_flow_ip", 32'(flow_ip), 32'd1);
    chk("start_not_ready", 32'(rd_ready), 32'd0);
    chk("start_entry", 32'(kv_rd_entry), 32'(entry));
    chk("start_done_clr", 32'(rd_done), 32'd0);
    chk("start_err_clr", 32'(rd_err), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"}, 32'(kv_rd_req), 32'd0);
    chk({tag, "_offset"}, 32'(kv_rd_offset), 32'd0);
    chk({tag, "_entry"}, 32'(kv_rd_entry), 32'd0);
    chk({tag, "_kwe"}, 32'(key_write_en), 32'd0);
    chk({tag, "_done"}, 32'(rd_done), 32'd0);
    chk({tag, "_err"}, 32'(rd_err), 32'd0);
    chk({tag, "_flow_ip"}, 32'(flow_ip), 32'd0);
    chk({tag, "_ready"}, 32'(rd_ready), 32'd1);
  endtask

  // Whole flow: expectations come from the dword count, error offset and latency
  task automatic run_flow(input string nm, input int entry, input int lat, input int err_off,
                          input int inject_cyc, input int lit_cyc);
    int n, cyc, w0;
    exp_q.delete();
    for (int i = 0; i < NUM && i < err_off; i++) exp_q.push_back('{3'(i), dword_of(i)});
    n = (err_off < NUM) ? err_off + 1 : NUM;
    vault_lat = lat; vault_err_off = err_off; vault_on = 1'b1;
    exp_entry = entry;
    w0 = writes_seen;
    start_flow(entry);
    req_cycles = 0;
    cyc = 0;
    while (!(rd_done || rd_err) && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == inject_cyc) begin
        ctrl_we = 1'b1;
        ctrl_wdata = {ENTRY_W'(7), 1'b1};
      end else begin
        ctrl_we = 1'b0;
      end
    end
    chk({nm, "_bounded"}, 32'(cyc < 2000), 32'd1);
    chk({nm, "_cycles_model"}, 32'(cyc), 32'(n * (lat + 1) + 1));
    chk({nm, "_cycles_literal"}, 32'(cyc), 32'(lit_cyc));
    chk({nm, "_req_cycles"}, 32'(req_cycles), 32'(n * (lat + 1)));
    chk({nm, "_writes"}, 32'(writes_seen - w0), 32'(n - ((err_off < NUM) ? 1 : 0)));
    chk({nm, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_done"}, 32'(rd_done), 32'(err_off >= NUM));
    chk({nm, "_err"}, 32'(rd_err), 32'(err_off < NUM));
    chk({nm, "_ready"}, 32'(rd_ready), 32'd1);
    chk({nm, "_entry_end"}, 32'(kv_rd_entry), 32'(entry));
  endtask

  initial begin
    int cyc, w0;
    reset = 1'b1;
    ctrl_we = 1'b0;
    ctrl_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // basic 8-dword fetch, 1-cycle vault
    run_flow("basic", 3, 1, 99, -1, 17);
    chk("basic_last_off", 32'(last_woff), 32'd7);
    chk("basic_last_data", last_wdata, 32'h8888_8888);

    // start write during WAIT must be ignored
    run_flow("inject", 3, 1, 99, 3, 17);

    // vault error on offset 4
    run_flow("error", 3, 1, 4, -1, 11);
    chk("error_last_off", 32'(last_woff), 32'd3);

    // 5-cycle vault latency
    run_flow("slow", 12, 5, 99, -1, 49);

    // response strobe in IDLE is ignored
    w0 = writes_seen;
    vault_on = 1'b0;
    @(posedge clk); #1;
    vault_spurious = 1'b1;
    @(posedge clk); #1;
    vault_spurious = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("spurious_no_write", 32'(writes_seen - w0), 32'd0);
    chk("spurious_ready", 32'(rd_ready), 32'd1);
    chk("spurious_no_flow", 32'(flow_ip), 32'd0);

    // reset while waiting on offset 2
    exp_q.delete();
    for (int i = 0; i < NUM; i++) exp_q.push_back('{3'(i), dword_of(i)});
    vault_lat = 1; vault_err_off = 99; vault_on = 1'b1; exp_entry = 3;
    w0 = writes_seen;
    start_flow(3);
    cyc = 0;
    while (cyc < 5) begin
      @(posedge clk); #1; cyc++;
    end
    chk("midreset_offset_before", 32'(kv_rd_offset), 32'd2);
    chk("midreset_req_before", 32'(kv_rd_req), 32'd1);
    reset = 1'b1;
    vault_on = 1'b0;
    #1;
    check_reset_values("midreset_now");
    exp_q.delete();
    @(posedge clk); #1;
    check_reset_values("midreset_next");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midreset_writes", 32'(writes_seen - w0), 32'd2);

    // silent vault
    exp_q.delete();
    vault_on = 1'b0;
    exp_entry = 9;
    start_flow(9);
    cyc = 0;
    while (!(rd_done || rd_err) && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
`ifdef KV_RD_TIMEOUT_EN
    chk("timeout_cycles", 32'(cyc), 32'd257);
    chk("timeout_err", 32'(rd_err), 32'd1);
    chk("timeout_ready", 32'(rd_ready), 32'd1);
`else
    chk("silent_req_held", 32'(kv_rd_req), 32'd1);
    chk("silent_flow_ip", 32'(flow_ip), 32'd1);
    chk("silent_no_err", 32'(rd_err), 32'd0);
    chk("silent_cycles", 32'(cyc), 32'd1000);
`endif
    reset = 1'b1;
    #1;
    check_reset_values("final_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_kv_key_reader.md
AES_KV_KEY_READER -- requirements
Module: aes_kv_key_reader

Interface
REQ-001 Parameter NUM_DWORDS, default 8, number of 32-bit key words fetched per flow (256-bit AES key).
REQ-002 Parameter ENTRY_W, default 5, width of the key-vault entry index.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ctrl_we  in  1  single-cycle write strobe for the read-control register.
REQ-006 ctrl_wdata  in  ENTRY_W+1  bit0 read_en (start), bits[ENTRY_W:1] entry index.
REQ-007 kv_rd_req  out  1  request to key vault, held until kv_rd_valid.
REQ-008 kv_rd_entry  out  ENTRY_W  latched entry index.
REQ-009 kv_rd_offset  out  3  dword offset being requested.
REQ-010 kv_rd_valid  in  1  response strobe, ≥1 cycle after kv_rd_req.
REQ-011 kv_rd_data  in  32  response dword, qualified by kv_rd_valid.
REQ-012 kv_rd_error  in  1  response error, qualified by kv_rd_valid.
REQ-013 key_write_en  out  1  one-cycle strobe writing a dword into the AES key register.
REQ-014 key_write_offset  out  3  key register index, equals offset just returned.
REQ-015 key_write_data  out  32  dword to write.
REQ-016 rd_ready  out  1  high in IDLE.
REQ-017 rd_done  out  1  sticky: last flow completed without error.
REQ-018 rd_err  out  1  sticky: last flow aborted on error.
REQ-019 flow_ip  out  1  high while a flow is active; forces AES keylen to 256b.

Function
REQ-020 FSM states IDLE, REQ, WAIT, DONE, ERR.
REQ-021 IDLE→REQ on ctrl_we with bit0=1; latch entry, clear offset counter, rd_done, rd_err.
REQ-022 ctrl_we in any state other than IDLE is ignored.
REQ-023 REQ asserts kv_rd_req and goes to WAIT next cycle; WAIT keeps kv_rd_req high.
REQ-024 WAIT with kv_rd_valid=1, kv_rd_error=0: key_write_en=1 same cycle (combinational from response), data/offset passthrough; offset increments.
REQ-025 After offset NUM_DWORDS-1 accepted, go to DONE; else REQ.
REQ-026 kv_rd_valid with kv_rd_error=1: no key write, go to ERR.
REQ-027 DONE sets rd_done, ERR sets rd_err, both return to IDLE next cycle.
REQ-028 Offset counter 3 bits, never wraps: halts at NUM_DWORDS-1.
REQ-029 kv_rd_valid outside WAIT is ignored.
REQ-030 Latency for 8 dwords with 1-cycle vault response: start to rd_done = 17 cycles.

Reset
REQ-031 On reset: state IDLE, kv_rd_req=0, offsets 0, entry 0, key_write_en=0, rd_done=0, rd_err=0, flow_ip=0, rd_ready=1.
REQ-032 Reset mid-flow abandons the flow immediately; no further key writes.

Configuration
REQ-033 Macro KV_RD_TIMEOUT_EN defined: 8-bit wait counter cleared on REQ; 255 cycles in WAIT without kv_rd_valid → ERR with rd_err=1.
REQ-034 Macro undefined: no counter; WAIT holds indefinitely.

Structure
REQ-035 State enum, control bit positions, and timeout limit constant live in shared package kv_defines_pkg.
REQ-036 No sub-module required; optional timeout counter is inline.

Verification
REQ-037 Start entry 3, vault returns 0x11111111..0x88888888 with 1-cycle latency → 8 key writes offsets 0..7 in order, rd_done=1 at cycle 17.
REQ-038 Error on offset 4 → 4 key writes only, rd_err=1, rd_done=0, rd_ready=1 next cycle.
REQ-039 ctrl_we during WAIT with entry 7 → ignored, kv_rd_entry stays 3.
REQ-040 Reset asserted in WAIT at offset 2 → all outputs at reset values next cycle, no key writes.
REQ-041 KV_RD_TIMEOUT_EN defined, vault silent → rd_err=1 after 255 WAIT cycles; undefined → kv_rd_req held after 1000 cycles.
REQ-042 Vault latency 5 cycles per dword → key writes correct, kv_rd_req held continuously in WAIT.
